// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm - multi-cycle control unit for the MIPS-subset datapath.
//
// Sequences FETCH / DECODE / execute / memory / write-back for each
// instruction and drives every datapath mux select and write enable.
// Memory states can optionally wait on a mem_req/mem_ready handshake.
// A watchdog bounds each wait and raises a sticky mem_timeout when it expires.
//
// Parameters
//   MEM_HANDSHAKE  0: memory states complete in one cycle, mem_ready ignored
//                  1: memory states hold until mem_ready (or watchdog expiry)
//   WDOG_CYCLES    maximum cycles per memory access (1..255)
//   CNT_W          width of the retired-instruction counter
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   OpCode, Funct         IR[31:26], IR[5:0]
//   Zero                  ALU zero flag (branch gating happens in the datapath)
//   mem_ready             memory access complete
//   PCWrite, PCWriteCond  PC write enables
//   IorD, MemRead, MemWrite, mem_req   memory address select and strobes
//   IRWrite, RegDst, MemtoReg, RegWrite   IR load and register-file write path
//   ALUSrcA, ALUSrcB, ExtOp, LuiOp, ALUOp ALU operand and operation selects
//   PCSource              next-PC select
//   illegal               one-cycle pulse in DECODE on an unknown opcode
//   mem_timeout           sticky watchdog flag, cleared only by reset
//   instr_count           retired instructions, wraps modulo 2^CNT_W
module mc_ctrl_fsm #(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned WDOG_CYCLES   = 64,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             mem_req,
    output logic             IRWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtOp,
    output logic             LuiOp,
    output logic [3:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_FUNCT = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_SLT   = 4'd4;
    localparam logic [3:0] ALU_SLTU  = 4'd5;

    localparam bit         HANDSHAKE = (MEM_HANDSHAKE != 0);
    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_req;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic       lui_op;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] wdog;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic       mem_state;
    logic       mem_done;
    logic       mem_expire;
    logic       is_shift;
    logic       unused_zero;

    // Zero only matters to the datapath's PCWriteCond gating.
    assign unused_zero = Zero;

    assign is_shift = (Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA);

    // mem_ready in the expiring cycle takes priority, so mem_expire
    // is only raised while mem_ready is low.
    always_comb begin
        mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
        if (HANDSHAKE) begin
            mem_done   = mem_ready;
            mem_expire = mem_state && !mem_ready && (wdog >= WDOG_LAST);
        end else begin
            mem_done   = 1'b1;
            mem_expire = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            wdog        <= '0;
            mem_timeout <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if ((next_state != state) || mem_expire) begin
                wdog <= '0;
            end else if (HANDSHAKE && mem_state && (wdog != 8'hff)) begin
                wdog <= wdog + 8'd1;
            end
            if (mem_expire) begin
                mem_timeout <= 1'b1;
            end
            if ((next_state == S_FETCH) && (state != S_FETCH)) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        ctrl       = '0;
        next_state = state;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = 2'd1;
                if (mem_done) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    next_state    = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'd3;
                ctrl.ext_op    = 1'b1;
                unique case (OpCode)
                    OP_RTYPE:                                 next_state = S_EXEC_R;
                    OP_LW, OP_SW:                             next_state = S_MEM_ADDR;
                    OP_LUI:                                   next_state = S_WB_I;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU: next_state = S_EXEC_I;
                    OP_BEQ:                                   next_state = S_BRANCH;
                    OP_J, OP_JAL:                             next_state = S_JUMP;
                    default: begin
                        ctrl.illegal = 1'b1;
                        next_state   = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.alu_src_a = is_shift ? 2'd3 : 2'd1;
                if (Funct == FN_JR) begin
                    ctrl.pc_source = 2'd3;
                    ctrl.pc_write  = 1'b1;
                    next_state     = S_FETCH;
                end else if (Funct == FN_JALR) begin
                    ctrl.reg_dst    = 2'd1;
                    ctrl.mem_to_reg = 2'd2;
                    ctrl.reg_write  = 1'b1;
                    ctrl.pc_source  = 2'd3;
                    ctrl.pc_write   = 1'b1;
                    next_state      = S_FETCH;
                end else begin
                    next_state = S_WB_R;
                end
            end
            S_WB_R: begin
                ctrl.reg_dst    = 2'd1;
                ctrl.mem_to_reg = 2'd1;
                ctrl.reg_write  = 1'b1;
                next_state      = S_FETCH;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 2'd1;
                ctrl.alu_src_b = 2'd2;
                ctrl.ext_op    = (OpCode != OP_ANDI);
                unique case (OpCode)
                    OP_ANDI:  ctrl.alu_op = ALU_AND;
                    OP_SLTI:  ctrl.alu_op = ALU_SLT;
                    OP_SLTIU: ctrl.alu_op = ALU_SLTU;
                    default:  ctrl.alu_op = ALU_ADD;
                endcase
                next_state = S_WB_I;
            end
            S_WB_I: begin
                ctrl.mem_to_reg = (OpCode == OP_LUI) ? 2'd3 : 2'd1;
                ctrl.lui_op     = (OpCode == OP_LUI);
                ctrl.reg_write  = 1'b1;
                next_state      = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 2'd1;
                ctrl.alu_src_b = 2'd2;
                ctrl.ext_op    = 1'b1;
                next_state     = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.mem_req  = 1'b1;
                if (mem_done) begin
                    next_state = S_MEM_WB;
                end else if (mem_expire) begin
                    next_state = S_FETCH;
                end
            end
            S_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                next_state     = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.mem_req   = 1'b1;
                if (mem_done || mem_expire) begin
                    next_state = S_FETCH;
                end
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 2'd1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = 2'd1;
                ctrl.pc_write_cond = 1'b1;
                next_state         = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_source = 2'd2;
                ctrl.pc_write  = 1'b1;
                if (OpCode == OP_JAL) begin
                    ctrl.reg_dst    = 2'd2;
                    ctrl.mem_to_reg = 2'd2;
                    ctrl.reg_write  = 1'b1;
                end
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held so they clear immediately,
    // not just once the state register has settled on FETCH.
    assign ctrl_out = reset ? '0 : ctrl;

    assign PCWrite     = ctrl_out.pc_write;
    assign PCWriteCond = ctrl_out.pc_write_cond;
    assign IorD        = ctrl_out.iord;
    assign MemRead     = ctrl_out.mem_read;
    assign MemWrite    = ctrl_out.mem_write;
    assign mem_req     = ctrl_out.mem_req;
    assign IRWrite     = ctrl_out.ir_write;
    assign RegDst      = ctrl_out.reg_dst;
    assign MemtoReg    = ctrl_out.mem_to_reg;
    assign RegWrite    = ctrl_out.reg_write;
    assign ALUSrcA     = ctrl_out.alu_src_a;
    assign ALUSrcB     = ctrl_out.alu_src_b;
    assign ExtOp       = ctrl_out.ext_op;
    assign LuiOp       = ctrl_out.lui_op;
    assign ALUOp       = ctrl_out.alu_op;
    assign PCSource    = ctrl_out.pc_source;
    assign illegal     = ctrl_out.illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm. Instance 0: no handshake, 4-bit counter.
// Instance 1: handshake with a 4-cycle watchdog, 32-bit counter.
// Stimulus expands each instruction into per-cycle expected control words
// and queues them. A negedge monitor pops and compares them.
module tb_mc_ctrl_fsm;

    localparam int WD = 4;

    typedef struct packed {
        logic [24:0] ctrl;
        logic        tmo;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic [5:0]  opc [2];
    logic [5:0]  fnc [2];
    logic        zro [2];
    logic        rdy [2];
    logic [24:0] got [2];
    logic        tmo [2];
    logic [31:0] cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned CW = (g == 0) ? 4 : 32;
        logic pcw, pcwc, iord, mrd, mwr, mreq, irw, rw, ext, lui, ill, mt;
        logic [1:0] rd, m2r, asa, asb, pcs;
        logic [3:0] aop;
        logic [CW-1:0] ic;

        mc_ctrl_fsm #(
            .MEM_HANDSHAKE(g),
            .WDOG_CYCLES  (WD),
            .CNT_W        (CW)
        ) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .OpCode     (opc[g]),
            .Funct      (fnc[g]),
            .Zero       (zro[g]),
            .mem_ready  (rdy[g]),
            .PCWrite    (pcw),
            .PCWriteCond(pcwc),
            .IorD       (iord),
            .MemRead    (mrd),
            .MemWrite   (mwr),
            .mem_req    (mreq),
            .IRWrite    (irw),
            .RegDst     (rd),
            .MemtoReg   (m2r),
            .RegWrite   (rw),
            .ALUSrcA    (asa),
            .ALUSrcB    (asb),
            .ExtOp      (ext),
            .LuiOp      (lui),
            .ALUOp      (aop),
            .PCSource   (pcs),
            .illegal    (ill),
            .mem_timeout(mt),
            .instr_count(ic)
        );

        assign got[g] = {pcw, pcwc, iord, mrd, mwr, mreq, irw, rd, m2r, rw,
                         asa, asb, ext, lui, aop, pcs, ill};
        assign tmo[g] = mt;
        assign cnt[g] = 32'(ic);
    end

    exp_t        q0[$];
    exp_t        q1[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        tflag [2];
    logic [31:0] cnt_m [2];
    logic [5:0]  i_op;
    logic [5:0]  i_fn;
    logic        i_z;

    function automatic logic [24:0] mk(
        input logic pcw, pcwc, iord, mrd, mwr, mreq, irw,
        input logic [1:0] rd, m2r, input logic rw, input logic [1:0] a, b,
        input logic ext, lu, input logic [3:0] aop, input logic [1:0] pcs,
        input logic ill);
        return {pcw, pcwc, iord, mrd, mwr, mreq, irw, rd, m2r, rw, a, b, ext, lu, aop, pcs, ill};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input int d, input exp_t e);
        n_cmp++;
        if (got[d] !== e.ctrl) begin
            n_bad++;
            $display("FAIL u%0d ctrl t=%0t got=%h exp=%h", d, $time, got[d], e.ctrl);
        end
        n_cmp++;
        if (tmo[d] !== e.tmo) begin
            n_bad++;
            $display("FAIL u%0d mem_timeout t=%0t got=%b exp=%b", d, $time, tmo[d], e.tmo);
        end
        n_cmp++;
        if (cnt[d] !== e.cnt) begin
            n_bad++;
            $display("FAIL u%0d instr_count t=%0t got=%0d exp=%0d", d, $time, cnt[d], e.cnt);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check(0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check(1, e);
            end
        end
    end

    task automatic push(input int d, input logic [24:0] c);
        exp_t e;
        e.ctrl = c;
        e.tmo  = tflag[d];
        e.cnt  = cnt_m[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One clock of an instruction; also releases the instance's reset.
    task automatic step(input int d, input logic r, input logic [24:0] c);
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
        opc[d] = i_op;
        fnc[d] = i_fn;
        zro[d] = i_z;
        rdy[d] = r;
        push(d, c);
    endtask

    // Memory access: ready after 'delay' low cycles, or watchdog abandon.
    task automatic mem_phase(input int d, input int delay, input logic [24:0] wait_c,
                             input logic [24:0] done_c, output bit ok);
        ok = 1'b0;
        if (d == 0) begin
            step(d, rnd(), done_c);
            ok = 1'b1;
        end else begin
            for (int i = 0; i < WD; i++) begin
                if (i == delay) begin
                    step(d, 1'b1, done_c);
                    ok = 1'b1;
                    break;
                end
                step(d, 1'b0, wait_c);
            end
            if (!ok) tflag[d] = 1'b1;
        end
    endtask

    task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int fd, input int md);
        bit          ok;
        bit          legal;
        bit          shift;
        logic [24:0] rd_c;
        logic [24:0] wr_c;
        i_op  = o;
        i_fn  = f;
        i_z   = z;
        legal = o inside {6'h00, 6'h23, 6'h2b, 6'h0f, 6'h08, 6'h09, 6'h0c,
                          6'h0a, 6'h0b, 6'h04, 6'h02, 6'h03};
        shift = f inside {6'h00, 6'h02, 6'h03};
        rd_c  = mk(0,0,1,1,0,1,0, 0,0,0, 0,0, 0,0, 0,0,0);
        wr_c  = mk(0,0,1,0,1,1,0, 0,0,0, 0,0, 0,0, 0,0,0);
        mem_phase(d, fd, mk(0,0,0,1,0,1,0, 0,0,0, 0,1, 0,0, 0,0,0),
                         mk(1,0,0,1,0,1,1, 0,0,0, 0,1, 0,0, 0,0,0), ok);
        step(d, rnd(), mk(0,0,0,0,0,0,0, 0,0,0, 0,3, 1,0, 0,0, !legal));
        if (legal) begin
            case (o)
                6'h00: begin
                    if (f == 6'h08)
                        step(d, rnd(), mk(1,0,0,0,0,0,0, 0,0,0, 1,0, 0,0, 2,3,0));
                    else if (f == 6'h09)
                        step(d, rnd(), mk(1,0,0,0,0,0,0, 1,2,1, 1,0, 0,0, 2,3,0));
                    else begin
                        step(d, rnd(), mk(0,0,0,0,0,0,0, 0,0,0, shift ? 2'd3 : 2'd1, 0, 0,0, 2,0,0));
                        step(d, rnd(), mk(0,0,0,0,0,0,0, 1,1,1, 0,0, 0,0, 0,0,0));
                    end
                end
                6'h23: begin
                    step(d, rnd(), mk(0,0,0,0,0,0,0, 0,0,0, 1,2, 1,0, 0,0,0));
                    mem_phase(d, md, rd_c, rd_c, ok);
                    if (ok) step(d, rnd(), mk(0,0,0,0,0,0,0, 0,0,1, 0,0, 0,0, 0,0,0));
                end
                6'h2b: begin
                    step(d, rnd(), mk(0,0,0,0,0,0,0, 0,0,0, 1,2, 1,0, 0,0,0));
                    mem_phase(d, md, wr_c, wr_c, ok);
                end
                6'h0f: step(d, rnd(), mk(0,0,0,0,0,0,0, 0,3,1, 0,0, 0,1, 0,0,0));
                6'h04: step(d, rnd(), mk(0,1,0,0,0,0,0, 0,0,0, 1,0, 0,0, 1,1,0));
                6'h02: step(d, rnd(), mk(1,0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 0,2,0));
                6'h03: step(d, rnd(), mk(1,0,0,0,0,0,0, 2,2,1, 0,0, 0,0, 0,2,0));
                default: begin
                    step(d, rnd(), mk(0,0,0,0,0,0,0, 0,0,0, 1,2, o != 6'h0c, 0,
                                      (o == 6'h0c) ? 4'd3 : (o == 6'h0a) ? 4'd4 :
                                      (o == 6'h0b) ? 4'd5 : 4'd0, 0,0));
                    step(d, rnd(), mk(0,0,0,0,0,0,0, 0,1,1, 0,0, 0,0, 0,0,0));
                end
            endcase
        end
        cnt_m[d] = (d == 0) ? ((cnt_m[d] + 32'd1) & 32'hf) : (cnt_m[d] + 32'd1);
    endtask

    task automatic rand_instr(input int d);
        logic [5:0] ops [13];
        logic [5:0] fns [15];
        logic [5:0] bad [5];
        logic [5:0] o;
        ops = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h0f, 6'h08, 6'h09, 6'h0c,
                6'h0a, 6'h0b, 6'h04, 6'h02, 6'h03};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};
        bad = '{6'h3f, 6'h01, 6'h05, 6'h20, 6'h11};
        if ($urandom_range(0, 9) == 0) o = bad[$urandom_range(0, 4)];
        else                           o = ops[$urandom_range(0, 12)];
        run_instr(d, o, fns[$urandom_range(0, 14)], rnd(),
                  $urandom_range(0, WD - 1), $urandom_range(0, WD - 1));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]   = 1'b1;
            opc[d]   = '0;
            fnc[d]   = '0;
            zro[d]   = 1'b0;
            rdy[d]   = 1'b0;
            tflag[d] = 1'b0;
            cnt_m[d] = '0;
        end
        i_op = '0;
        i_fn = '0;
        i_z  = 1'b0;

        // Reset state of both instances.
        @(posedge clk);
        #1;
        push(0, '0);
        push(1, '0);

        // Instance 0: fixed-latency memory.
        run_instr(0, 6'h00, 6'h21, 1'b0, 0, 0); // addu
        run_instr(0, 6'h23, 6'h00, 1'b0, 0, 0); // lw
        run_instr(0, 6'h2b, 6'h00, 1'b0, 0, 0); // sw
        run_instr(0, 6'h04, 6'h00, 1'b1, 0, 0); // beq, Zero=1
        run_instr(0, 6'h03, 6'h00, 1'b0, 0, 0); // jal
        run_instr(0, 6'h3f, 6'h00, 1'b0, 0, 0); // illegal
        run_instr(0, 6'h00, 6'h00, 1'b0, 0, 0); // sll
        run_instr(0, 6'h00, 6'h08, 1'b0, 0, 0); // jr
        run_instr(0, 6'h0f, 6'h00, 1'b0, 0, 0); // lui
        for (int k = 0; k < 30; k++) rand_instr(0);
        @(posedge clk);
        #1;
        rst[0] = 1'b1;

        // Instance 1: handshake memory with watchdog.
        for (int k = 0; k < 25; k++) rand_instr(1);
        run_instr(1, 6'h23, 6'h00, 1'b0, 3, 2);  // lw, ready late in FETCH and MEM_RD
        run_instr(1, 6'h2b, 6'h00, 1'b0, 0, 3);  // sw, ready in last watchdog cycle
        run_instr(1, 6'h2b, 6'h00, 1'b0, 0, 99); // sw, watchdog expires
        run_instr(1, 6'h00, 6'h21, 1'b0, 1, 0);  // addu after timeout
        run_instr(1, 6'h3f, 6'h00, 1'b0, 0, 0);  // illegal
        run_instr(1, 6'h23, 6'h00, 1'b0, 2, 1);  // lw

        // Asynchronous reset while waiting in MEM_RD.
        i_op = 6'h23;
        i_fn = 6'h00;
        step(1, 1'b1, mk(1,0,0,1,0,1,1, 0,0,0, 0,1, 0,0, 0,0,0));
        step(1, 1'b0, mk(0,0,0,0,0,0,0, 0,0,0, 0,3, 1,0, 0,0,0));
        step(1, 1'b0, mk(0,0,0,0,0,0,0, 0,0,0, 1,2, 1,0, 0,0,0));
        step(1, 1'b0, mk(0,0,1,1,0,1,0, 0,0,0, 0,0, 0,0, 0,0,0));
        @(posedge clk);
        #3;
        rdy[1]   = 1'b0;
        rst[1]   = 1'b1;
        tflag[1] = 1'b0;
        cnt_m[1] = '0;
        push(1, '0);
        @(posedge clk);
        #1;
        push(1, '0);
        run_instr(1, 6'h00, 6'h21, 1'b0, 2, 0);  // restarts at FETCH
        run_instr(1, 6'h23, 6'h00, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        n_cmp++;
        if (q0.size() + q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending exp=0", q0.size() + q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
